pn_checker: RTL and testbench

Receive-side companion to the 5-stage PN generator: consumes the serial PN bit stream and self-synchronises a local 5-bit LFSR to it. Once locked, it flywheels the sequence, flags and counts bit errors for BER measurement, and drops lock when the error rate is too high. It sits at the end of the Hamming encode/channel/decode loopback path, before the test-status registers.

---
 rtl/pn_checker.sv | 132 +++++++++++++
 tb/tb_pn_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_checker.sv
// pn_checker: self-synchronising PN5 sequence checker with lock detection and BER counters
module pn_checker #(
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_WINDOW = 32,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] bit_count
);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [4:0]           sh_q, sh_d;
    logic [2:0]           fill_q, fill_d;
    logic [7:0]           match_q, match_d;
    logic [7:0]           win_cnt_q, win_cnt_d;
    logic [7:0]           win_err_q, win_err_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

    logic       pred, mis;
    logic [7:0] match_inc, win_err_inc;

    assign pred        = sh_q[3] ^ sh_q[0];
    assign mis         = din ^ pred;
    assign match_inc   = match_q + 8'd1;
    assign win_err_inc = win_err_q + {7'd0, mis};

    // Next-state: search fill, self-synchronising verify, flywheel with windowed loss detection
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    sh_d   = {din, sh_q[4:1]};
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd4) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    sh_d = {din, sh_q[4:1]};
                    if (!mis && sh_q != '0) begin
                        match_d = match_inc;
                        if (match_inc == 8'(LOCK_THRESH)) begin
                            state_d   = LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sh_d        = {pred, sh_q[4:1]};
                    err_pulse_d = mis;
                    bit_cnt_d   = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + CNT_WIDTH'(1);
                    err_cnt_d   = (mis && err_cnt_q != '1) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
                    if (win_err_inc == 8'(LOSS_THRESH)) begin
                        state_d   = SEARCH;
                        fill_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == 8'(LOSS_WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;
endmodule

// File: tb/tb_pn_checker.sv
// tb_pn_checker: scoreboard-driven bench for the PN5 sequence checker
module tb_pn_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count, bit_count;
    logic [33:0] obs;
    logic [33:0] q[$];
    logic [30:0] seq;
    int          ph = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign obs = {locked, err_pulse, err_count, bit_count};

    pn_checker dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    function automatic logic nb(input logic flip);
        logic r;
        r = seq[ph] ^ flip;
        ph = (ph + 1) % 31;
        return r;
    endfunction

    task automatic send(input logic b, input logic v, input logic c);
        din = b;
        din_valid = v;
        clr_cnt = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = 0;
    endtask

    task automatic get_lock();
        logic [33:0] e;
        do_reset();
        repeat (21) send(nb(1'b0), 1'b1, 1'b0);
        q.push_back({1'b1, 1'b0, 16'd0, 16'd0});
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL get_lock: got %h want %h (locked,err_pulse,err_count,bit_count)", obs, e);
        end
    endtask

    task automatic test_reset();
        logic [33:0] e;
        #3;
        q.push_back('0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, e);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) send(1'b1, 1'b0, 1'b0);
        q.push_back('0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", obs, e);
        end
    endtask

    task automatic test_clean_lock();
        logic [33:0] e;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            q.push_back({i >= 21, 1'b0, 16'd0, 16'(i >= 21 ? i - 21 : 0)});
            send(nb(1'b0), 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL clean_lock bit %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_single_error();
        logic [33:0] e;
        logic [15:0] ec;
        logic        f;
        get_lock();
        ec = 16'd0;
        for (int j = 1; j <= 12; j++) begin
            f = (j == 3);
            ec = ec + 16'(f);
            q.push_back({1'b1, f, ec, 16'(j)});
            send(nb(f), 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL single_error bit %0d: got %h want %h", j, obs, e);
            end
        end
    endtask

    task automatic test_loss();
        logic [33:0] e;
        logic [15:0] ec, bc;
        logic        f, lk, lk_n;
        get_lock();
        ec = 16'd0;
        bc = 16'd0;
        lk = 1'b1;
        for (int j = 1; j <= 34; j++) begin
            f = (j inside {3, 5, 7, 9});
            bc = bc + 16'(lk);
            ec = ec + 16'(lk & f);
            lk_n = (j < 9) || (j >= 30);
            q.push_back({lk_n, f & lk, ec, bc});
            send(nb(f), 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL loss_relock bit %0d: got %h want %h", j, obs, e);
            end
            lk = lk_n;
        end
    endtask

    task automatic test_window();
        logic [33:0] e;
        logic [15:0] ec;
        logic        f;
        get_lock();
        ec = 16'd0;
        for (int j = 1; j <= 40; j++) begin
            f = (j inside {30, 31, 32, 33});
            ec = ec + 16'(f);
            q.push_back({1'b1, f, ec, 16'(j)});
            send(nb(f), 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL window_boundary bit %0d: got %h want %h", j, obs, e);
            end
        end
    endtask

    task automatic test_zero();
        logic [33:0] e;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            q.push_back('0);
            send(1'b0, 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL all_zero bit %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_gapped();
        logic [33:0] e;
        logic [15:0] bc;
        logic        v, b, lk;
        int          nv;
        do_reset();
        nv = 0;
        bc = 16'd0;
        lk = 1'b0;
        for (int c = 1; c <= 46; c++) begin
            v = (c % 2 == 1);
            b = v ? nb(1'b0) : 1'($urandom_range(0, 1));
            bc = bc + 16'(v & lk);
            nv = nv + int'(v);
            lk = (nv >= 21);
            q.push_back({lk, 1'b0, 16'd0, bc});
            send(b, v, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL gapped cycle %0d: got %h want %h", c, obs, e);
            end
        end
    endtask

    task automatic test_clear();
        logic [33:0] e;
        get_lock();
        repeat (3) send(nb(1'b0), 1'b1, 1'b0);
        q.push_back({1'b1, 1'b1, 16'd0, 16'd0});
        send(nb(1'b1), 1'b1, 1'b1);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_with_error: got %h want %h", obs, e);
        end
        q.push_back({1'b1, 1'b0, 16'd0, 16'd1});
        send(nb(1'b0), 1'b1, 1'b0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL count_after_clear: got %h want %h", obs, e);
        end
        q.push_back({1'b1, 1'b0, 16'd0, 16'd0});
        send(1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_in_bubble: got %h want %h", obs, e);
        end
        q.push_back({1'b1, 1'b1, 16'd1, 16'd1});
        send(nb(1'b1), 1'b1, 1'b0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL error_after_clear: got %h want %h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] e;
        get_lock();
        send(nb(1'b1), 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        q.push_back('0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, e);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            q.push_back({i == 21, 1'b0, 16'd0, 16'd0});
            send(nb(1'b0), 1'b1, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL relock_after_reset bit %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    initial begin
        seq[4:0] = 5'b01101;
        for (int k = 0; k < 26; k++) seq[k+5] = seq[k+3] ^ seq[k];
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss();
        test_window();
        test_zero();
        test_gapped();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
